// File: rtl/bpu_pkg.sv
// Shared types for the branch predictor: table-entry layout, 2-bit counter
// encodings and small helpers used by both the table and the top level.
package bpu_pkg;

    localparam int unsigned ENTRIES = 64;
    // Tag is stored at full width so any ENTRIES value fits the same entry type.
    localparam int unsigned TAG_W   = 30;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        ctr_e             ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step.
    function automatic ctr_e ctr_step(input ctr_e c, input logic up);
        ctr_e n;
        n = c;
        if (up && (c != CTR_ST))
            n = ctr_e'(c + 2'd1);
        else if (!up && (c != CTR_SNT))
            n = ctr_e'(c - 2'd1);
        return n;
    endfunction

    // Tag bits of a PC: everything above the word offset and the index.
    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc, input int unsigned idx_w);
        return TAG_W'(pc >> (idx_w + 2));
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and decode-side resolution signals of the branch predictor.
// master: pipeline driving PCs and resolution; slave: the predictor.
interface branch_predictor_if;
    logic [31:0] PC_F;
    logic [31:0] PC_BP;
    logic        BP_WR;
    logic        br_valid_D;
    logic        br_taken_D;
    logic [31:0] br_target_D;
    logic [31:0] PC4_D;
    logic        mispredict;
    logic [31:0] PC_FIX;

    modport master (
        output PC_F, br_valid_D, br_taken_D, br_target_D, PC4_D,
        input  PC_BP, BP_WR, mispredict, PC_FIX
    );

    modport slave (
        input  PC_F, br_valid_D, br_taken_D, br_target_D, PC4_D,
        output PC_BP, BP_WR, mispredict, PC_FIX
    );
endinterface

// File: rtl/bpu_btb_ram.sv
// Branch target buffer storage: two async read ports (fetch lookup and
// decode-side training lookup), one sync write port, async clear of valid/ctr.
module bpu_btb_ram
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES  = bpu_pkg::ENTRIES,
    parameter ctr_e        CTR_INIT = CTR_WNT,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_f_idx_i,
    output btb_entry_t       rd_f_o,
    input  logic [IDX_W-1:0] rd_d_idx_i,
    output btb_entry_t       rd_d_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  btb_entry_t       wr_entry_i
);

    logic             valid_q  [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];

    // Valid bits and counters: cleared by reset, written on update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_INIT;
            end
        end else if (we_i) begin
            valid_q[wr_idx_i] <= wr_entry_i.valid;
            ctr_q[wr_idx_i]   <= wr_entry_i.ctr;
        end
    end

    // Tags and targets carry no reset; they are meaningless while valid=0.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]    <= wr_entry_i.tag;
            target_q[wr_idx_i] <= wr_entry_i.target;
        end
    end

    // Async read ports; a same-cycle write is seen only after the edge.
    always_comb begin
        rd_f_o.valid  = valid_q[rd_f_idx_i];
        rd_f_o.tag    = tag_q[rd_f_idx_i];
        rd_f_o.target = target_q[rd_f_idx_i];
        rd_f_o.ctr    = ctr_q[rd_f_idx_i];
        rd_d_o.valid  = valid_q[rd_d_idx_i];
        rd_d_o.tag    = tag_q[rd_d_idx_i];
        rd_d_o.target = target_q[rd_d_idx_i];
        rd_d_o.ctr    = ctr_q[rd_d_idx_i];
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB + 2-bit direction predictor. Fetch lookup drives PC_BP/BP_WR; decode
// compares the carried prediction with the resolved branch and trains the table.
// Optional BPU_STATS_EN adds br_cnt/mispred_cnt event counters.
module branch_predictor
    import bpu_pkg::*;
#(
    parameter int unsigned ENTRIES  = bpu_pkg::ENTRIES,
    parameter ctr_e        CTR_INIT = CTR_WNT,
    localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    branch_predictor_if.slave  bp
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]        br_cnt,
    output logic [31:0]        mispred_cnt
`endif
);

    logic [31:0]      pc_d;
    logic [IDX_W-1:0] idx_f, idx_d;
    btb_entry_t       ent_f, ent_d, wr_entry;
    logic             hit_f, hit_d, we, upd_en;
    logic             pred_taken_q, pred_taken_d;
    logic [31:0]      pred_target_q, pred_target_d;

    assign pc_d   = bp.PC4_D - 32'd4;
    assign idx_f  = bp.PC_F[IDX_W+1:2];
    assign idx_d  = pc_d[IDX_W+1:2];
    assign upd_en = !stall && !flush;

    bpu_btb_ram #(
        .ENTRIES  (ENTRIES),
        .CTR_INIT (CTR_INIT)
    ) u_btb (
        .clk        (clk),
        .rst        (reset),
        .rd_f_idx_i (idx_f),
        .rd_f_o     (ent_f),
        .rd_d_idx_i (idx_d),
        .rd_d_o     (ent_d),
        .we_i       (we),
        .wr_idx_i   (idx_d),
        .wr_entry_i (wr_entry)
    );

    // Fetch-side prediction and decode-side hit detection.
    always_comb begin
        hit_f     = ent_f.valid && (ent_f.tag == tag_of(bp.PC_F, IDX_W));
        hit_d     = ent_d.valid && (ent_d.tag == tag_of(pc_d, IDX_W));
        bp.BP_WR  = hit_f && ent_f.ctr[1];
        bp.PC_BP  = hit_f ? ent_f.target : '0;
    end

    // F->D prediction register next state: flush clears, stall holds.
    always_comb begin
        pred_taken_d  = pred_taken_q;
        pred_target_d = pred_target_q;
        if (flush) begin
            pred_taken_d  = 1'b0;
            pred_target_d = '0;
        end else if (!stall) begin
            pred_taken_d  = bp.BP_WR;
            pred_target_d = bp.PC_BP;
        end
    end

    // F->D prediction register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pred_taken_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            pred_taken_q  <= pred_taken_d;
            pred_target_q <= pred_target_d;
        end
    end

    // Misprediction check against the resolved branch and corrective PC.
    always_comb begin
        bp.mispredict = (bp.br_valid_D && (pred_taken_q != bp.br_taken_D))
                     || (bp.br_valid_D && bp.br_taken_D && pred_taken_q
                         && (pred_target_q != bp.br_target_D))
                     || (!bp.br_valid_D && pred_taken_q);
        bp.PC_FIX     = (bp.br_valid_D && bp.br_taken_D) ? bp.br_target_D : bp.PC4_D;
    end

    // Table training: counter update on hit, allocate on taken miss,
    // invalidate an entry that predicted taken for a non-branch.
    always_comb begin
        we       = 1'b0;
        wr_entry = ent_d;
        if (upd_en) begin
            if (bp.br_valid_D && hit_d) begin
                we           = 1'b1;
                wr_entry.ctr = ctr_step(ent_d.ctr, bp.br_taken_D);
                if (bp.br_taken_D)
                    wr_entry.target = bp.br_target_D;
            end else if (bp.br_valid_D && bp.br_taken_D) begin
                we              = 1'b1;
                wr_entry.valid  = 1'b1;
                wr_entry.tag    = tag_of(pc_d, IDX_W);
                wr_entry.target = bp.br_target_D;
                wr_entry.ctr    = CTR_WT;
            end else if (!bp.br_valid_D && hit_d && pred_taken_q) begin
                we             = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

`ifdef BPU_STATS_EN
    logic [31:0] br_cnt_q, mispred_cnt_q;

    // Branch and mispredict event counters, wrapping at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else if (upd_en) begin
            if (bp.br_valid_D)
                br_cnt_q <= br_cnt_q + 32'd1;
            if (bp.mispredict)
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

endmodule
